// File: rtl/twofish_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// twofish_arb_pkg
// Shared widths, the arbiter state encoding and a small width helper used by
// twofish_arbiter and its round-robin grant sub-module.
// -----------------------------------------------------------------------------
package twofish_arb_pkg;

    localparam int BLOCK_W = 128;
    localparam int KEY_W   = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int id_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/twofish_arbiter_rr_grant.sv
// -----------------------------------------------------------------------------
// rr_grant
// Combinational round-robin selector: picks the first valid requester at or
// after the priority pointer, wrapping around.
// Ports:
//   i_valid [N_REQ]  request valid vector
//   i_ptr   [ID_W]   index with highest priority this cycle
//   o_gnt   [N_REQ]  one-hot grant (all zero when nothing is valid)
//   o_idx   [ID_W]   index of the granted requester
//   o_any            any requester valid
// -----------------------------------------------------------------------------
module rr_grant
    import twofish_arb_pkg::*;
#(
    parameter  int N_REQ = 2,
    localparam int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] i_valid,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_any
);

    int   w_pos;
    logic w_found;

    // Scan from the pointer upward, wrapping, and keep only the first hit.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_pos   = 0;
        w_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if ((int'(i_ptr) + i) < N_REQ) begin
                w_pos = int'(i_ptr) + i;
            end else begin
                w_pos = int'(i_ptr) + i - N_REQ;
            end
            if (!w_found && i_valid[ID_W'(w_pos)]) begin
                w_found              = 1'b1;
                o_gnt[ID_W'(w_pos)]  = 1'b1;
                o_idx                = ID_W'(w_pos);
            end else begin
                w_found = w_found;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/twofish_arbiter.sv
// -----------------------------------------------------------------------------
// twofish_arbiter
// Shares one twofish core between N_REQ requesters. One operation is in flight
// at a time: IDLE grants round-robin and latches operands, LOAD holds the core
// in reset one cycle with stable operands, RUN releases the core and waits for
// completion or a timeout, RESP holds the result until the consumer accepts.
// Ports:
//   clk, rst (synchronous, active low)
//   req_valid_i/req_ready_o/req_block_i/req_key_i/req_encdec_i : requesters
//   rsp_valid_o/rsp_ready_i/rsp_block_o/rsp_id_o/rsp_timeout_o : result
//   core_rst_o/core_key_o/core_block_o/core_encdec_o           : to core
//   core_block_i/core_end_i                                     : from core
// -----------------------------------------------------------------------------
module twofish_arbiter
    import twofish_arb_pkg::*;
#(
    parameter  int N_REQ          = 2,
    parameter  int TIMEOUT_CYCLES = 4096,
    localparam int ID_W           = id_width(N_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_REQ-1:0]                req_valid_i,
    output logic [N_REQ-1:0]                req_ready_o,
    input  logic [N_REQ-1:0][BLOCK_W-1:0]   req_block_i,
    input  logic [N_REQ-1:0][KEY_W-1:0]     req_key_i,
    input  logic [N_REQ-1:0]                req_encdec_i,
    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic [BLOCK_W-1:0]              rsp_block_o,
    output logic [ID_W-1:0]                 rsp_id_o,
    output logic                            rsp_timeout_o,
    output logic                            core_rst_o,
    output logic [KEY_W-1:0]                core_key_o,
    output logic [BLOCK_W-1:0]              core_block_o,
    output logic                            core_encdec_o,
    input  logic [BLOCK_W-1:0]              core_block_i,
    input  logic                            core_end_i
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    arb_state_e         r_state;
    arb_state_e         w_next;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    w_ptr_next;
    logic [15:0]        r_cnt;
    logic [KEY_W-1:0]   r_core_key;
    logic [BLOCK_W-1:0] r_core_block;
    logic               r_core_encdec;
    logic [BLOCK_W-1:0] r_rsp_block;
    logic [ID_W-1:0]    r_rsp_id;
    logic               r_rsp_timeout;
    logic [N_REQ-1:0]   w_gnt;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;

    rr_grant #(
        .N_REQ (N_REQ)
    ) u_rr_grant (
        .i_valid (req_valid_i),
        .i_ptr   (r_ptr),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Pointer moves to the requester after the one just granted.
    always_comb begin
        if (w_idx == ID_W'(N_REQ - 1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_idx + ID_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; completion is tested before timeout so it wins a tie.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_next = ST_LOAD;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_LOAD: w_next = ST_RUN;
            ST_RUN: begin
                if (core_end_i || (r_cnt == TMO_LAST)) begin
                    w_next = ST_RESP;
                end else begin
                    w_next = ST_RUN;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_RESP;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand latch at grant, RUN cycle counter and result capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr         <= '0;
            r_cnt         <= 16'd0;
            r_core_key    <= '0;
            r_core_block  <= '0;
            r_core_encdec <= 1'b0;
            r_rsp_block   <= '0;
            r_rsp_id      <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_core_key    <= req_key_i[w_idx];
                        r_core_block  <= req_block_i[w_idx];
                        r_core_encdec <= req_encdec_i[w_idx];
                        r_rsp_id      <= w_idx;
                        r_ptr         <= w_ptr_next;
                    end
                end
                ST_LOAD: r_cnt <= 16'd0;
                ST_RUN: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (core_end_i) begin
                        r_rsp_block   <= core_block_i;
                        r_rsp_timeout <= 1'b0;
                    end else if (r_cnt == TMO_LAST) begin
                        r_rsp_block   <= '0;
                        r_rsp_timeout <= 1'b1;
                    end
                end
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Handshake and core hold decode; everything is forced safe while rst is low
    // so nothing leaks out between the reset request and the clock edge.
    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = 1'b0;
        core_rst_o  = 1'b1;
        if (!rst) begin
            req_ready_o = '0;
            rsp_valid_o = 1'b0;
            core_rst_o  = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: req_ready_o = w_gnt;
                ST_RUN:  core_rst_o  = 1'b0;
                ST_RESP: rsp_valid_o = 1'b1;
                default: core_rst_o  = 1'b1;
            endcase
        end
    end

    assign rsp_block_o   = r_rsp_block;
    assign rsp_id_o      = r_rsp_id;
    assign rsp_timeout_o = r_rsp_timeout;
    assign core_key_o    = r_core_key;
    assign core_block_o  = r_core_block;
    assign core_encdec_o = r_core_encdec;

endmodule

// File: tb/tb_twofish_arbiter.sv
module tb_twofish_arbiter;

    localparam int TMO = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       req_valid_i = 2'b00;
    logic [1:0]       req_ready_o;
    logic [1:0][127:0] req_block_i = '0;
    logic [1:0][127:0] req_key_i = '0;
    logic [1:0]       req_encdec_i = 2'b00;
    logic             rsp_valid_o;
    logic             rsp_ready_i = 1'b0;
    logic [127:0]     rsp_block_o;
    logic [0:0]       rsp_id_o;
    logic             rsp_timeout_o;
    logic             core_rst_o;
    logic [127:0]     core_key_o;
    logic [127:0]     core_block_o;
    logic             core_encdec_o;
    logic [127:0]     core_block_i;
    logic             core_end_i;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   dly = 0;
    int   stub_cnt = 0;
    logic spur = 1'b0;
    logic spur_en = 1'b0;

    // reference model state (transaction level)
    bit           m_busy = 0;
    int           m_ptr = 0;
    int           m_t, m_exp, m_id;
    logic         m_tmo, m_enc;
    logic [127:0] m_blk, m_key, m_inblk;

    always #5 clk = ~clk;

    twofish_arbiter #(.N_REQ(2), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_block_i(req_block_i), .req_key_i(req_key_i), .req_encdec_i(req_encdec_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_block_o(rsp_block_o),
        .rsp_id_o(rsp_id_o), .rsp_timeout_o(rsp_timeout_o),
        .core_rst_o(core_rst_o), .core_key_o(core_key_o), .core_block_o(core_block_o),
        .core_encdec_o(core_encdec_o), .core_block_i(core_block_i), .core_end_i(core_end_i)
    );

    function automatic logic [127:0] stub_f(input logic [127:0] k, input logic [127:0] b, input logic e);
        return k ^ {b[63:0], b[127:64]} ^ {128{e}} ^ 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // stub core: ends `dly` cycles after release; spurious ends while held
    always @(posedge clk) begin
        if (core_rst_o) stub_cnt <= 0;
        else            stub_cnt <= stub_cnt + 1;
    end
    assign core_end_i   = core_rst_o ? spur : (stub_cnt == dly);
    assign core_block_i = stub_f(core_key_o, core_block_o, core_encdec_o);

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_check();
        logic [1:0] eg;
        int g;
        int p;
        logic ev;
        if (!rst) begin
            chk("rst_ready", req_ready_o, 0);
            chk("rst_core_rst", core_rst_o, 1);
            chk("rst_rsp_valid", rsp_valid_o, 0);
            m_busy = 0;
            m_ptr = 0;
        end else if (!m_busy) begin
            g = -1;
            for (int i = 0; i < 2; i++) begin
                p = (m_ptr + i) % 2;
                if (g < 0 && req_valid_i[p[0]]) g = p;
            end
            eg = (g >= 0) ? (2'b01 << g) : 2'b00;
            chk("grant", req_ready_o, eg);
            chk("idle_rsp_valid", rsp_valid_o, 0);
            chk("idle_core_rst", core_rst_o, 1);
            if (g >= 0) begin
                m_busy = 1;
                m_t = cyc;
                m_id = g;
                m_ptr = (g + 1) % 2;
                m_key = req_key_i[g[0]];
                m_inblk = req_block_i[g[0]];
                m_enc = req_encdec_i[g[0]];
                if (dly <= TMO - 1) begin
                    m_exp = cyc + 3 + dly; m_tmo = 0; m_blk = stub_f(m_key, m_inblk, m_enc);
                end else begin
                    m_exp = cyc + 2 + TMO; m_tmo = 1; m_blk = '0;
                end
            end
        end else begin
            ev = (cyc >= m_exp);
            chk("busy_ready", req_ready_o, 0);
            chk("rsp_valid", rsp_valid_o, ev);
            chk("core_rst", core_rst_o, !(cyc >= m_t + 2 && cyc < m_exp));
            chk("core_key", core_key_o, m_key);
            chk("core_block", core_block_o, m_inblk);
            chk("core_encdec", core_encdec_o, m_enc);
            if (ev) begin
                chk("rsp_block", rsp_block_o, m_blk);
                chk("rsp_id", rsp_id_o, m_id);
                chk("rsp_timeout", rsp_timeout_o, m_tmo);
                if (rsp_ready_i) m_busy = 0;
            end
        end
    endtask

    task automatic step(input logic [1:0] v, input logic rdy, input logic rv);
        @(posedge clk);
        #1;
        cyc++;
        rst = rv;
        req_valid_i = v;
        rsp_ready_i = rdy;
        req_key_i[0] = rnd128();
        req_key_i[1] = rnd128();
        req_block_i[0] = rnd128();
        req_block_i[1] = rnd128();
        req_encdec_i = 2'($urandom_range(0, 3));
        spur = spur_en & 1'($urandom_range(0, 1));
        #1;
        model_check();
    endtask

    typedef struct {
        logic [1:0] valid;
        int         dly;
        int         hold;
        int         exp_id;
        logic       exp_tmo;
        int         exp_lat;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int t0;
        int gid;
        int seen;
        bit got;

        tbl[0] = '{2'b11, 20,  0, 0, 1'b0, 23};
        tbl[1] = '{2'b11, 5,   0, 1, 1'b0, 8};
        tbl[2] = '{2'b01, 0,  10, 0, 1'b0, 3};
        tbl[3] = '{2'b10, 100, 0, 1, 1'b1, 66};
        tbl[4] = '{2'b10, 63,  0, 1, 1'b0, 66};
        tbl[5] = '{2'b11, 64,  0, 0, 1'b1, 66};
        tbl[6] = '{2'b11, 1,   0, 1, 1'b0, 4};

        // reset state
        step(2'b11, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0);
        chk("reset_rsp_block", rsp_block_o, 0);
        chk("reset_rsp_id", rsp_id_o, 0);
        chk("reset_rsp_timeout", rsp_timeout_o, 0);
        chk("reset_core_key", core_key_o, 0);
        chk("reset_core_block", core_block_o, 0);

        // table-driven operations
        for (int e = 0; e < 7; e++) begin
            dly = tbl[e].dly;
            got = 0;
            gid = -1;
            t0 = 0;
            for (int c = 0; c < 10 && !got; c++) begin
                step(tbl[e].valid, 1'b0, 1'b1);
                if (req_ready_o != 2'b00) begin
                    got = 1; t0 = cyc; gid = (req_ready_o == 2'b10) ? 1 : 0;
                end
            end
            chk("tbl_grant_seen", got, 1);
            chk("tbl_grant_id", gid, tbl[e].exp_id);
            got = 0;
            for (int c = 0; c < 200 && !got; c++) begin
                step(tbl[e].valid, 1'b0, 1'b1);
                if (rsp_valid_o) got = 1;
            end
            chk("tbl_rsp_seen", got, 1);
            chk("tbl_latency", cyc - t0, tbl[e].exp_lat);
            chk("tbl_timeout", rsp_timeout_o, tbl[e].exp_tmo);
            for (int w = 0; w < tbl[e].hold; w++) step(tbl[e].valid, 1'b0, 1'b1);
            step(tbl[e].valid, 1'b1, 1'b1);
        end

        // reset pulse in the middle of RUN discards the operation
        dly = 30;
        step(2'b01, 1'b0, 1'b1);
        chk("midrst_grant", req_ready_o, 2'b01);
        for (int c = 0; c < 10; c++) step(2'b00, 1'b1, 1'b1);
        step(2'b00, 1'b1, 1'b0);
        step(2'b00, 1'b1, 1'b1);
        chk("midrst_core_rst", core_rst_o, 1);
        chk("midrst_rsp_block", rsp_block_o, 0);
        chk("midrst_core_key", core_key_o, 0);
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            step(2'b00, 1'b1, 1'b1);
            if (rsp_valid_o) seen++;
        end
        chk("midrst_no_rsp", seen, 0);

        // randomized traffic against the reference model
        spur_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (!m_busy) begin
                case ($urandom_range(0, 5))
                    0:       dly = 63;
                    1:       dly = 64 + $urandom_range(0, 40);
                    default: dly = $urandom_range(0, 15);
                endcase
            end
            step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 299) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/twofish_arbiter.md
TWOFISH_ARBITER -- requirements
Module: twofish_arbiter

Interface
REQ-001 Parameter N_REQ, default 2: number of requesters sharing the single twofish core.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: maximum RUN cycles before an operation is abandoned.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 req_valid_i  input  N_REQ  per-requester request valid.
REQ-006 req_ready_o  output  N_REQ  per-requester accept; at most one bit high per cycle.
REQ-007 req_block_i  input  N_REQ x 128  per-requester text input.
REQ-008 req_key_i  input  N_REQ x 128  per-requester key.
REQ-009 req_encdec_i  input  N_REQ  per-requester direction (1 = encrypt).
REQ-010 rsp_valid_o  output  1  result available.
REQ-011 rsp_ready_i  input  1  result consumer accept.
REQ-012 rsp_block_o  output  128  result text.
REQ-013 rsp_id_o  output  clog2(N_REQ)  index of the requester that owns the result.
REQ-014 rsp_timeout_o  output  1  result abandoned by timeout.
REQ-015 core_rst_o  output  1  active-high hold/reset to the core; high = core idle.
REQ-016 core_key_o, core_block_o  output  128 each  registered operands to the core.
REQ-017 core_encdec_o  output  1  registered direction to the core.
REQ-018 core_block_i  input  128  core text output.
REQ-019 core_end_i  input  1  core completion.

Function
REQ-020 FSM states: IDLE, LOAD, RUN, RESP.
REQ-021 IDLE: core_rst_o=1; if any req_valid_i is high, grant the first valid index at or after rr_ptr (wrapping), drive req_ready_o[grant]=1 combinationally in that cycle only, latch that requester's key, block and encdec into the core operand registers and the grant into rsp_id, set rr_ptr=grant+1 mod N_REQ, go to LOAD.
REQ-022 req_ready_o is 0 in every state except IDLE; valid requests not granted are neither consumed nor latched.
REQ-023 LOAD: one cycle with core_rst_o=1 and operands stable; go to RUN.
REQ-024 RUN: core_rst_o=0; 16-bit-capable counter starts at 0 in the first RUN cycle and increments each cycle.
REQ-025 RUN with core_end_i=1: register core_block_i into rsp_block, rsp_timeout=0, go to RESP.
REQ-026 RUN with counter==TIMEOUT_CYCLES-1 and core_end_i=0: rsp_block=0, rsp_timeout=1, go to RESP; if both occur in the same cycle, completion wins.
REQ-027 RESP: core_rst_o=1; rsp_valid_o=1; rsp_block_o, rsp_id_o, rsp_timeout_o held stable until rsp_valid_o && rsp_ready_i, then go to IDLE.
REQ-028 Latency: request accepted in cycle T, core_end_i in RUN cycle index k -> rsp_valid_o high from cycle T+3+k; timeout -> rsp_valid_o high from cycle T+2+TIMEOUT_CYCLES.
REQ-029 core_end_i is ignored outside RUN.
REQ-030 A new grant cannot occur earlier than the cycle after the response handshake; one operation in flight.

Reset
REQ-031 rst=0 at any clock edge, including mid-RUN or mid-RESP: state=IDLE, rr_ptr=0, counter=0, rsp_valid_o=0, rsp_timeout_o=0, rsp_block_o=0, rsp_id_o=0, core operand registers=0, core_rst_o=1, req_ready_o=0 while rst=0; any in-flight result is discarded.

Structure
REQ-032 Package twofish_arb_pkg holds BLOCK_W=128, KEY_W=128 and the state enum.
REQ-033 Round-robin grant selection is one sub-module, rr_grant (valid vector, pointer -> one-hot grant, index).

Verification
REQ-034 req0 only, stub core ends 20 cycles after release -> req_ready_o[0] for one cycle at T, rsp_valid_o at T+23, rsp_id_o=0, rsp_block_o=stub value.
REQ-035 Both requests valid in the first cycle after reset -> req0 served first, then req1; req_ready_o never 2'b11.
REQ-036 rsp_ready_i held low 10 cycles -> rsp outputs constant, no req_ready_o pulse, core_rst_o=1 throughout.
REQ-037 Stub never ends, TIMEOUT_CYCLES=64 -> rsp_valid_o at T+66 with rsp_timeout_o=1, rsp_block_o=0.
REQ-038 rst=0 for one cycle during RUN -> next cycle IDLE, core_rst_o=1, rsp_valid_o=0, no response ever issued for that request.
REQ-039 Real core, key=0, block=0, encrypt -> rsp_block_o=9F589F5CF6122C32B6BFEC2F2AE8C35A, rsp_timeout_o=0.
